// File: rtl/mips_defs_pkg.sv
// Shared MIPS definitions for the HI/LO multiply/divide unit:
// opcode constants, FSM state encodings, the divide-by-zero quotient
// and a small opcode-decode helper.
package mips_defs;

    // MDU opcodes carried on the op port
    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Quotient reported for any divide by zero
    localparam logic [31:0] MDU_DIV_ZERO_Q = 32'hFFFF_FFFF;

    // True for the opcodes that treat their operands as two's complement
    function automatic logic mdu_is_signed(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // Trial subtraction; the remainder is restored when the divisor does not fit
    always_comb begin
        w_shift = {i_rem, i_bit};
        w_diff  = w_shift - {1'b0, i_divisor};
        if (w_shift >= {1'b0, i_divisor}) begin
            o_rem = w_diff[WIDTH-1:0];
            o_q   = 1'b1;
        end else begin
            o_rem = w_shift[WIDTH-1:0];
            o_q   = 1'b0;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit for the MIPS execute stage.
// Iterative shift-add multiply and restoring divide, one step per cycle,
// operating on magnitudes with sign correction on the final step.
// Optional build macro MDU_FAST_MULT_EN: MULT/MULTU complete in a single
// cycle through a combinational multiplier; divides remain iterative.
module mult_div_unit
    import mips_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;      // mult: {partial sum, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   r_opb;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_is_div;
    logic               r_dz;
    logic               r_neg_q;    // product or quotient must be negated
    logic               r_neg_r;    // remainder must be negated
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH-1:0]   w_div_rem;
    logic               w_div_q;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_step_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;
    logic               w_last;

    assign w_accept = start && (r_state != ST_RUN);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // Operand sign detection and magnitude conversion for signed opcodes
    always_comb begin
        w_a_neg = mdu_is_signed(op) & rs_data[WIDTH-1];
        w_b_neg = mdu_is_signed(op) & rt_data[WIDTH-1];
        if (w_a_neg) begin
            w_a_mag = -rs_data;
        end else begin
            w_a_mag = rs_data;
        end
        if (w_b_neg) begin
            w_b_mag = -rt_data;
        end else begin
            w_b_mag = rt_data;
        end
    end

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .i_rem     (r_acc[2*WIDTH-1:WIDTH]),
        .i_bit     (r_acc[WIDTH-1]),
        .i_divisor (r_opb),
        .o_rem     (w_div_rem),
        .o_q       (w_div_q)
    );

    // Next accumulator value for one multiply or divide iteration
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
        w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
        w_div_next = {w_div_rem, r_acc[WIDTH-2:0], w_div_q};
        if (r_is_div) begin
            w_step_next = w_div_next;
        end else begin
            w_step_next = w_mul_next;
        end
    end

    // Sign correction of the final iteration into HI/LO results
    always_comb begin
        w_prod = r_neg_q ? -w_step_next : w_step_next;
        w_quo  = r_neg_q ? -w_step_next[WIDTH-1:0] : w_step_next[WIDTH-1:0];
        // With a zero divisor the remainder path already reproduces the dividend
        w_rem  = r_neg_r ? -w_step_next[2*WIDTH-1:WIDTH] : w_step_next[2*WIDTH-1:WIDTH];
        if (r_is_div) begin
            w_res_hi = w_rem;
            if (r_dz) begin
                w_res_lo = WIDTH'(MDU_DIV_ZERO_Q);
            end else begin
                w_res_lo = w_quo;
            end
        end else begin
            w_res_hi = w_prod[2*WIDTH-1:WIDTH];
            w_res_lo = w_prod[WIDTH-1:0];
        end
    end

`ifdef MDU_FAST_MULT_EN
    logic [2*WIDTH-1:0] w_fast_mag;
    logic [2*WIDTH-1:0] w_fast_prod;

    // Single-cycle multiply on operand magnitudes
    always_comb begin
        w_fast_mag = {{WIDTH{1'b0}}, w_a_mag} * {{WIDTH{1'b0}}, w_b_mag};
        if (w_a_neg ^ w_b_neg) begin
            w_fast_prod = -w_fast_mag;
        end else begin
            w_fast_prod = w_fast_mag;
        end
    end
`endif

    // FSM, operand capture, iteration and HI/LO update
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_dz     <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (w_accept) begin
            case (op)
                MDU_MULT, MDU_MULTU: begin
`ifdef MDU_FAST_MULT_EN
                    r_hi    <= w_fast_prod[2*WIDTH-1:WIDTH];
                    r_lo    <= w_fast_prod[WIDTH-1:0];
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
`else
                    r_acc    <= {{WIDTH{1'b0}}, w_b_mag};
                    r_opb    <= w_a_mag;
                    r_is_div <= 1'b0;
                    r_dz     <= 1'b0;
                    r_neg_q  <= w_a_neg ^ w_b_neg;
                    r_neg_r  <= 1'b0;
                    r_cnt    <= '0;
                    r_state  <= ST_RUN;
                    r_busy   <= 1'b1;
                    r_done   <= 1'b0;
`endif
                end
                MDU_DIV, MDU_DIVU: begin
                    r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
                    r_opb    <= w_b_mag;
                    r_is_div <= 1'b1;
                    r_dz     <= (rt_data == '0);
                    r_neg_q  <= w_a_neg ^ w_b_neg;
                    r_neg_r  <= w_a_neg;
                    r_cnt    <= '0;
                    r_state  <= ST_RUN;
                    r_busy   <= 1'b1;
                    r_done   <= 1'b0;
                end
                MDU_MTHI: begin
                    r_hi    <= rs_data;
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                MDU_MTLO: begin
                    r_lo    <= rs_data;
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    // NOP: only a pending DONE cycle retires
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_acc <= w_step_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_hi    <= w_res_hi;
                        r_lo    <= w_res_lo;
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                ST_IDLE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed boundary cases plus
// randomized operations compared against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
    import mips_defs::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] rs_data;
    logic [W-1:0] rt_data;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural result of an arithmetic op, from plain integer arithmetic
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        eh = m_hi;
        el = m_lo;
        case (o)
            MDU_MULT: begin
                p  = 64'(sa * sb);
                eh = p[63:32];
                el = p[31:0];
            end
            MDU_MULTU: begin
                p  = {32'd0, a} * {32'd0, b};
                eh = p[63:32];
                el = p[31:0];
            end
            MDU_DIV, MDU_DIVU: begin
                if (b == 32'd0) begin
                    eh = a;
                    el = 32'hFFFF_FFFF;
                end else if (o == MDU_DIV) begin
                    q  = 64'(sa / sb);
                    r  = 64'(sa % sb);
                    eh = r[31:0];
                    el = q[31:0];
                end else begin
                    eh = a % b;
                    el = a / b;
                end
            end
            default: begin
                eh = m_hi;
                el = m_lo;
            end
        endcase
    endfunction

    // Issue one arithmetic op and check latency, busy/done and HI/LO hold;
    // returns in the DONE cycle so the caller may chain another start
    task automatic do_arith(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            input bit interfere);
        logic [31:0] eh;
        logic [31:0] el;
        bit          run_ok;
        bit          fast;
        model(o, a, b, eh, el);
        fast = 1'b0;
`ifdef MDU_FAST_MULT_EN
        fast = (o == MDU_MULT) || (o == MDU_MULTU);
`endif
        op      = o;
        rs_data = a;
        rt_data = b;
        start   = 1'b1;
        tick;
        start   = 1'b0;
        if (fast) begin
            chk("fast_busy_done", 64'({busy, done}), 64'd1);
        end else begin
            run_ok = 1'b1;
            for (int i = 0; i < W; i++) begin
                if (!(busy === 1'b1 && done === 1'b0 && hi === m_hi && lo === m_lo)) begin
                    run_ok = 1'b0;
                end
                if (interfere && i == 5) begin
                    start   = 1'b1;
                    op      = MDU_MTHI;
                    rs_data = 32'hDEAD_BEEF;
                end
                if (interfere && i == 6) begin
                    start = 1'b0;
                end
                tick;
            end
            chk("run_busy_hold", 64'(run_ok), 64'd1);
            chk("end_busy_done", 64'({busy, done}), 64'd1);
        end
        chk("result_hi", 64'(hi), 64'(eh));
        chk("result_lo", 64'(lo), 64'(el));
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic idle_check;
        tick;
        chk("done_clear", 64'({busy, done}), 64'd0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        reset   = 1'b1;
        start   = 1'b0;
        op      = 3'd0;
        rs_data = '0;
        rt_data = '0;
        tick;
        tick;
        reset = 1'b0;
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_busy_done", 64'({busy, done}), 64'd0);

        // Directed arithmetic cases
        do_arith(MDU_MULT,  32'hFFFF_FFFE, 32'd3, 1'b0);
        idle_check;
        do_arith(MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
        idle_check;
        do_arith(MDU_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
        idle_check;
        do_arith(MDU_DIVU,  32'd7, 32'd2, 1'b0);
        idle_check;
        do_arith(MDU_DIVU,  32'd5, 32'd0, 1'b0);
        idle_check;
        do_arith(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle_check;
        do_arith(MDU_DIV,   32'hFFFF_FFF9, 32'd0, 1'b0);
        idle_check;

        // MTHI then MTLO on consecutive cycles
        start   = 1'b1;
        op      = MDU_MTHI;
        rs_data = 32'h0000_1234;
        tick;
        chk("mthi_hi", 64'(hi), 64'h1234);
        chk("mthi_done", 64'({busy, done}), 64'd0);
        op      = MDU_MTLO;
        rs_data = 32'h0000_5678;
        tick;
        start   = 1'b0;
        chk("mtlo_hi", 64'(hi), 64'h1234);
        chk("mtlo_lo", 64'(lo), 64'h5678);
        chk("mtlo_done", 64'({busy, done}), 64'd0);
        m_hi = 32'h0000_1234;
        m_lo = 32'h0000_5678;

        // NOP leaves everything unchanged
        start = 1'b1;
        op    = 3'd6;
        tick;
        start = 1'b0;
        chk("nop_state", 64'({busy, done}), 64'd0);
        chk("nop_hilo", {hi, lo}, {m_hi, m_lo});

        // A start during RUN is ignored
        do_arith(MDU_DIVU, 32'd100, 32'd7, 1'b1);
        idle_check;

        // Back-to-back: new start accepted in the DONE cycle
        do_arith(MDU_MULTU, 32'd123, 32'd456, 1'b0);
        do_arith(MDU_DIV, 32'hFFFF_FF00, 32'd16, 1'b0);
        idle_check;

        // Reset aborts a running op
        op      = MDU_DIVU;
        rs_data = 32'd1000;
        rt_data = 32'd3;
        start   = 1'b1;
        tick;
        start   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("abort_hilo", {hi, lo}, 64'd0);
        chk("abort_busy_done", 64'({busy, done}), 64'd0);
        m_hi = '0;
        m_lo = '0;
        tick;
        chk("abort_stays_idle", 64'({busy, done}), 64'd0);
        do_arith(MDU_MULTU, 32'd6, 32'd7, 1'b0);
        idle_check;

        // Randomized arithmetic against the model
        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i % 6 == 0) begin
                rb = 32'd0;
            end else if (i % 5 == 1) begin
                rb = 32'($urandom_range(1, 15));
            end
            if (i % 7 == 3) begin
                ra = 32'h8000_0000;
            end
            do_arith(ro, ra, rb, 1'b0);
            if (i % 2 == 1) begin
                idle_check;
            end
        end
        idle_check;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
